// File: rtl/tea_io_mailbox.sv
// Byte mailbox on the tea_cpu io_* bus: host->CPU RX FIFO, CPU->host TX FIFO,
// sticky status flags, occupancy counters and a scratch register.
module tea_io_mailbox #(
    parameter int FIFO_DEPTH_LOG2 = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] io_addr,
    input  logic       io_rd,
    input  logic       io_wr,
    input  logic [7:0] io_wrdata,
    output logic [7:0] io_rddata,
    input  logic       rx_valid,
    output logic       rx_ready,
    input  logic [7:0] rx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       irq
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int PW    = FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [4:0] ADDR_DATA    = 5'h00;
    localparam logic [4:0] ADDR_STATUS  = 5'h01;
    localparam logic [4:0] ADDR_RXCOUNT = 5'h02;
    localparam logic [4:0] ADDR_TXCOUNT = 5'h03;
    localparam logic [4:0] ADDR_SCRATCH = 5'h04;

    logic          strobe_q, strobe_d;
    logic [7:0]    rx_mem_q [DEPTH];
    logic [7:0]    rx_mem_d [DEPTH];
    logic [7:0]    tx_mem_q [DEPTH];
    logic [7:0]    tx_mem_d [DEPTH];
    logic [PW-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic [PW-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic          rx_unf_q, rx_unf_d, tx_ovf_q, tx_ovf_d;
    logic [7:0]    scratch_q, scratch_d;
    logic [7:0]    rddata_q, rddata_d;

    logic       commit, rd_commit, wr_commit;
    logic       rx_empty, rx_full, tx_empty, tx_full;
    logic       rx_push, rx_pop, tx_push, tx_pop;
    logic       rx_unf_set, tx_ovf_set, status_wr;
    logic [7:0] status;

    // Only the first strobe cycle commits; the second cycle is side-effect free.
    always_comb begin
        commit     = (io_rd || io_wr) && !strobe_q;
        rd_commit  = commit && io_rd;
        wr_commit  = commit && io_wr;
        rx_empty   = (rx_cnt_q == '0);
        rx_full    = (rx_cnt_q == FULL_CNT);
        tx_empty   = (tx_cnt_q == '0);
        tx_full    = (tx_cnt_q == FULL_CNT);
        rx_push    = rx_valid && rx_ready;
        rx_pop     = rd_commit && (io_addr == ADDR_DATA) && !rx_empty;
        rx_unf_set = rd_commit && (io_addr == ADDR_DATA) && rx_empty;
        tx_push    = wr_commit && (io_addr == ADDR_DATA) && !tx_full;
        tx_ovf_set = wr_commit && (io_addr == ADDR_DATA) && tx_full;
        tx_pop     = tx_valid && tx_ready;
        status_wr  = wr_commit && (io_addr == ADDR_STATUS);
        status     = {2'b00, tx_ovf_q, rx_unf_q, tx_full, tx_empty, rx_full, !rx_empty};
    end

    assign rx_ready  = !rst && !rx_full;
    assign tx_valid  = !tx_empty;
    assign tx_data   = tx_mem_q[tx_rd_ptr_q];
    assign irq       = !rx_empty || rx_unf_q || tx_ovf_q;
    assign io_rddata = rddata_q;

    always_comb begin
        strobe_d    = io_rd || io_wr;
        rx_mem_d    = rx_mem_q;
        tx_mem_d    = tx_mem_q;
        rx_wr_ptr_d = rx_wr_ptr_q;
        rx_rd_ptr_d = rx_rd_ptr_q;
        tx_wr_ptr_d = tx_wr_ptr_q;
        tx_rd_ptr_d = tx_rd_ptr_q;
        rx_cnt_d    = rx_cnt_q;
        tx_cnt_d    = tx_cnt_q;
        scratch_d   = scratch_q;
        rddata_d    = rddata_q;

        if (rx_push) begin
            rx_mem_d[rx_wr_ptr_q] = rx_data;
            rx_wr_ptr_d           = rx_wr_ptr_q + PW'(1);
        end
        if (rx_pop) begin
            rx_rd_ptr_d = rx_rd_ptr_q + PW'(1);
        end
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + CW'(1);
            2'b01:   rx_cnt_d = rx_cnt_q - CW'(1);
            default: rx_cnt_d = rx_cnt_q;
        endcase

        if (tx_push) begin
            tx_mem_d[tx_wr_ptr_q] = io_wrdata;
            tx_wr_ptr_d           = tx_wr_ptr_q + PW'(1);
        end
        if (tx_pop) begin
            tx_rd_ptr_d = tx_rd_ptr_q + PW'(1);
        end
        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + CW'(1);
            2'b01:   tx_cnt_d = tx_cnt_q - CW'(1);
            default: tx_cnt_d = tx_cnt_q;
        endcase

        // A set event in the same cycle as its W1C wins.
        rx_unf_d = (rx_unf_q && !(status_wr && io_wrdata[4])) || rx_unf_set;
        tx_ovf_d = (tx_ovf_q && !(status_wr && io_wrdata[5])) || tx_ovf_set;

        if (wr_commit && (io_addr == ADDR_SCRATCH)) begin
            scratch_d = io_wrdata;
        end

        // Read data is a snapshot of state before this edge's pushes and pops.
        if (rd_commit) begin
            case (io_addr)
                ADDR_DATA:    rddata_d = rx_empty ? 8'h00 : rx_mem_q[rx_rd_ptr_q];
                ADDR_STATUS:  rddata_d = status;
                ADDR_RXCOUNT: rddata_d = 8'(rx_cnt_q);
                ADDR_TXCOUNT: rddata_d = 8'(tx_cnt_q);
                ADDR_SCRATCH: rddata_d = scratch_q;
                default:      rddata_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            strobe_q    <= 1'b0;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            rx_cnt_q    <= '0;
            tx_cnt_q    <= '0;
            rx_unf_q    <= 1'b0;
            tx_ovf_q    <= 1'b0;
            scratch_q   <= 8'h00;
            rddata_q    <= 8'h00;
        end else begin
            strobe_q    <= strobe_d;
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            rx_cnt_q    <= rx_cnt_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_unf_q    <= rx_unf_d;
            tx_ovf_q    <= tx_ovf_d;
            scratch_q   <= scratch_d;
            rddata_q    <= rddata_d;
        end
    end

    // Storage needs no reset; the counts alone define which entries are live.
    always_ff @(posedge clk) begin
        rx_mem_q <= rx_mem_d;
        tx_mem_q <= tx_mem_d;
    end

endmodule

// File: tb/tb_tea_io_mailbox.sv
// Randomized scoreboard bench for tea_io_mailbox against a queue-based mailbox model.
module tb_tea_io_mailbox;

    localparam int LOG2  = 3;
    localparam int DEPTH = 1 << LOG2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] io_addr = '0;
    logic       io_rd = 1'b0;
    logic       io_wr = 1'b0;
    logic [7:0] io_wrdata = '0;
    logic [7:0] io_rddata;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [7:0] rx_data = '0;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic [7:0] tx_data;
    logic       irq;

    tea_io_mailbox #(.FIFO_DEPTH_LOG2(LOG2)) dut (
        .clk(clk), .rst(rst), .io_addr(io_addr), .io_rd(io_rd), .io_wr(io_wr),
        .io_wrdata(io_wrdata), .io_rddata(io_rddata), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .rx_data(rx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_data(tx_data), .irq(irq)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model of the mailbox contents, plus scoreboard queues of expected outputs.
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] exp_rd[$];
    logic [7:0] exp_tx[$];
    logic       unf = 1'b0;
    logic       ovf = 1'b0;
    logic [7:0] scratch = 8'h00;
    logic       rd_prev = 1'b0;

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_status();
        return {2'b00, ovf, unf, tx_q.size() == DEPTH, tx_q.size() == 0,
                rx_q.size() == DEPTH, rx_q.size() != 0};
    endfunction

    task automatic model_reset();
        rx_q.delete();
        tx_q.delete();
        unf     = 1'b0;
        ovf     = 1'b0;
        scratch = 8'h00;
    endtask

    task automatic predict_read(input logic [4:0] a, output logic [7:0] v);
        case (a)
            5'h00: begin
                if (rx_q.size() == 0) begin
                    v   = 8'h00;
                    unf = 1'b1;
                end else begin
                    v = rx_q.pop_front();
                end
            end
            5'h01:   v = model_status();
            5'h02:   v = 8'(rx_q.size());
            5'h03:   v = 8'(tx_q.size());
            5'h04:   v = scratch;
            default: v = 8'h00;
        endcase
    endtask

    task automatic predict_write(input logic [4:0] a, input logic [7:0] d);
        case (a)
            5'h00: begin
                if (tx_q.size() == DEPTH) ovf = 1'b1;
                else tx_q.push_back(d);
            end
            5'h01: begin
                if (d[4]) unf = 1'b0;
                if (d[5]) ovf = 1'b0;
            end
            5'h04:   scratch = d;
            default: ;
        endcase
    endtask

    task automatic cpu_read(input logic [4:0] a);
        logic [7:0] v;
        @(posedge clk); #1;
        io_addr = a;
        io_rd   = 1'b1;
        predict_read(a, v);
        exp_rd.push_back(v);
        @(posedge clk); #1;
        @(posedge clk); #1;
        io_rd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [4:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        io_addr   = a;
        io_wrdata = d;
        io_wr     = 1'b1;
        predict_write(a, d);
        @(posedge clk); #1;
        @(posedge clk); #1;
        io_wr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic host_push(input logic [7:0] d);
        @(posedge clk); #1;
        checkOutput("rx_ready", 8'(rx_ready), 8'(rx_q.size() < DEPTH));
        rx_valid = 1'b1;
        rx_data  = d;
        if (rx_q.size() < DEPTH) rx_q.push_back(d);
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic host_pop();
        @(posedge clk); #1;
        checkOutput("tx_valid", 8'(tx_valid), 8'(tx_q.size() != 0));
        tx_ready = 1'b1;
        if (tx_q.size() != 0) exp_tx.push_back(tx_q.pop_front());
        @(posedge clk); #1;
        tx_ready = 1'b0;
    endtask

    task automatic check_irq();
        checkOutput("irq", 8'(irq), 8'((rx_q.size() != 0) || unf || ovf));
    endtask

    // Monitor: read data is presented in the second strobe cycle; TX bytes on handshake.
    always @(negedge clk) begin
        if (io_rd && rd_prev) begin
            if (exp_rd.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL rd_unexpected: got 0x%02h expected none", io_rddata);
            end else begin
                checkOutput("rd_data", io_rddata, exp_rd.pop_front());
            end
        end
        rd_prev = io_rd;
        if (tx_valid && tx_ready) begin
            if (exp_tx.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL tx_unexpected: got 0x%02h expected none", tx_data);
            end else begin
                checkOutput("tx_data", tx_data, exp_tx.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        failures++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic [7:0] v;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_rx_ready", 8'(rx_ready), 8'h00);
        checkOutput("rst_tx_valid", 8'(tx_valid), 8'h00);
        checkOutput("rst_irq", 8'(irq), 8'h00);
        checkOutput("rst_rddata", io_rddata, 8'h00);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("idle_rx_ready", 8'(rx_ready), 8'h01);
        checkOutput("idle_tx_valid", 8'(tx_valid), 8'h00);
        cpu_read(5'h01);
        cpu_read(5'h02);

        // RX ordering and underflow
        host_push(8'h11);
        host_push(8'h22);
        host_push(8'h33);
        cpu_read(5'h02);
        repeat (3) cpu_read(5'h00);
        cpu_read(5'h02);
        cpu_read(5'h00);
        cpu_read(5'h01);
        check_irq();
        cpu_write(5'h01, 8'h10);
        check_irq();
        cpu_read(5'h01);

        // TX overflow then drain
        for (int i = 0; i < 9; i++) cpu_write(5'h00, 8'hA0 + 8'(i));
        cpu_read(5'h03);
        cpu_read(5'h01);
        for (int i = 0; i < 9; i++) host_pop();
        checkOutput("tx_drained", 8'(tx_valid), 8'h00);
        cpu_write(5'h01, 8'h20);
        check_irq();

        // RX full, then a DATA read while the host is still offering a byte
        for (int i = 0; i < DEPTH; i++) host_push(8'($urandom));
        host_push(8'hEE);
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_data  = 8'hC7;
        io_addr  = 5'h00;
        io_rd    = 1'b1;
        checkOutput("full_rx_ready", 8'(rx_ready), 8'h00);
        exp_rd.push_back(rx_q.pop_front());
        @(posedge clk); #1;
        checkOutput("reopen_rx_ready", 8'(rx_ready), 8'h01);
        rx_q.push_back(8'hC7);
        @(posedge clk); #1;
        io_rd    = 1'b0;
        rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cpu_read(5'h02);
        for (int i = 0; i < DEPTH; i++) cpu_read(5'h00);

        // Scratch and unmapped address
        cpu_write(5'h04, 8'h5A);
        cpu_read(5'h04);
        cpu_write(5'h1F, 8'hFF);
        cpu_read(5'h1F);

        // Reset during a DATA read with one byte waiting
        host_push(8'h77);
        @(posedge clk); #1;
        io_addr = 5'h00;
        io_rd   = 1'b1;
        rst     = 1'b1;
        exp_rd.push_back(8'h00);
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        io_rd = 1'b0;
        rst   = 1'b0;
        checkOutput("rddata_after_rst", io_rddata, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        cpu_read(5'h02);
        cpu_read(5'h04);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 6))
                0, 1: host_push(8'($urandom));
                2:    host_pop();
                3:    cpu_read(5'($urandom_range(0, 4)));
                4:    cpu_read(($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h00);
                5:    cpu_write(5'h00, 8'($urandom));
                default: begin
                    v = 8'($urandom);
                    cpu_write(($urandom_range(0, 1) == 0) ? 5'h01 : 5'($urandom), v);
                end
            endcase
            check_irq();
        end
        cpu_read(5'h01);
        cpu_read(5'h02);
        cpu_read(5'h03);

        repeat (4) @(posedge clk);
        #1;
        checkOutput("rd_scoreboard_empty", 8'(exp_rd.size()), 8'h00);
        checkOutput("tx_scoreboard_empty", 8'(exp_tx.size()), 8'h00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
